// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes,
// FSM state encoding and the per-access load descriptor.
package lsu_pkg;

  // funct3 access-size codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Captured when the access is issued. Once the pipeline advances, the EX
  // inputs no longer describe the load, so extraction uses this copy.
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] off;
  } load_info_t;

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus: request channel (master drives) plus grant/response
// channel (memory drives).
interface lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables/replicated write data,
// access legality, and load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op_funct3,
  input  logic [1:0]  op_off,
  input  logic        op_is_store,
  input  logic [31:0] op_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        bad,
  input  load_info_t  ld_info,
  input  logic [31:0] rdata,
  output logic [31:0] load_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {ld_info.off, 3'b000};

  // Store lane placement and legality of the EX-stage access
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    be    = 4'b1111;
    wdata = 32'h0;
    bad   = 1'b0;
    case (op_funct3)
      F3_B: begin
        if (op_is_store) begin
          be    = 4'b0001 << op_off;
          wdata = {4{op_data[7:0]}};
        end
      end
      F3_H: begin
        bad = op_off[0];
        if (op_is_store) begin
          be    = 4'b0011 << op_off;
          wdata = {2{op_data[15:0]}};
        end
      end
      F3_W: begin
        bad = |op_off;
        if (op_is_store) wdata = op_data;
      end
      F3_BU:   bad = op_is_store;
      F3_HU:   bad = op_is_store | op_off[0];
      default: bad = 1'b1;
    endcase
  end

  // Load result extraction from the raw memory word
  always_comb begin
    load_ext = rdata;
    case (ld_info.funct3)
      F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_ext = {24'h0, shifted[7:0]};
      F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_ext = {16'h0, shifted[15:0]};
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between EX and MEM/WB. Issues one data-memory access per
// EX-stage memory op over a req/gnt/rvalid bus, stalls the pipeline while the
// access is in flight, and registers the extended load result.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  lsu_if.master       dmem,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = $clog2(BUS_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             kill_q;
  load_info_t       ld_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;

  logic             access;
  logic             expire;
  logic             kill_now;
  logic             stall;
  logic             misalign;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata;
  logic             al_bad;
  logic [31:0]      al_load;

  assign access   = valid_i & (mem_read_i | mem_write_i) & ~flush_i;
  // The counter shares one budget across REQ and WAIT; this is the last cycle of it.
  assign expire   = (cnt_q == CNT_W'(BUS_TIMEOUT - 1));
  // A flush coinciding with the response must also discard it.
  assign kill_now = kill_q | flush_i;

  lsu_align u_align (
    .op_funct3   (funct3_i),
    .op_off      (addr_i[1:0]),
    .op_is_store (mem_write_i),
    .op_data     (store_data_i),
    .be          (al_be),
    .wdata       (al_wdata),
    .bad         (al_bad),
    .ld_info     (ld_q),
    .rdata       (dmem.rdata),
    .load_ext    (al_load)
  );

  // Next-state, stall and misalign decode
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    misalign = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (al_bad) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (dmem.gnt)     state_d = we_q ? S_DONE : S_WAIT;
        else if (flush_i) state_d = S_IDLE;
        else if (expire)  state_d = S_DONE;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dmem.rvalid) state_d = kill_now ? S_IDLE : S_DONE;
        else if (expire) state_d = S_DONE;
      end
      S_DONE: begin
        if (!hold_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_o    = stall & ~rst_i;
  assign misalign_o = misalign & ~rst_i;

  // FSM state register
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request capture, timeout counter, kill flag and load result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      ld_q        <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      load_data_o <= 32'h0;
      bus_err_o   <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_REQ) begin
            addr_q  <= {addr_i[31:2], 2'b00};
            wdata_q <= al_wdata;
            be_q    <= al_be;
            we_q    <= mem_write_i;
            ld_q    <= '{funct3: funct3_i, off: addr_i[1:0]};
            cnt_q   <= '0;
            kill_q  <= 1'b0;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem.gnt) begin
            // A load granted in the flush cycle still returns data; drop it later.
            kill_q <= flush_i;
          end else if (!flush_i && expire) begin
            bus_err_o   <= 1'b1;
            load_data_o <= 32'h0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem.rvalid) begin
            if (!kill_now) load_data_o <= al_load;
          end else begin
            if (flush_i) kill_q <= 1'b1;
            if (expire) begin
              bus_err_o   <= 1'b1;
              load_data_o <= 32'h0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.req   = (state_q == S_REQ);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized loads and
// stores against a behavioural model of lane placement, extension and latency.
module tb_lsu;
  import lsu_pkg::*;

  localparam int unsigned T = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i, hold_i, valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic [31:0] load_data_o;
  logic        stall_o, misalign_o, bus_err_o;

  lsu_if dmem ();

  lsu #(.BUS_TIMEOUT(T)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .hold_i       (hold_i),
    .valid_i      (valid_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .dmem         (dmem),
    .load_data_o  (load_data_o),
    .stall_o      (stall_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_ld = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 1;
      F3_H, F3_HU: return 2;
      F3_W:        return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit legal(input bit wr, input logic [2:0] f3, input logic [1:0] off);
    int sz = size_of(f3);
    if (sz == 0) return 0;
    if (wr && f3[2]) return 0;
    return (int'(off) % sz) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input bit wr, input logic [2:0] f3, input logic [1:0] off);
    int b;
    if (!wr) return 4'hF;
    b = ((1 << size_of(f3)) - 1) << off;
    return b[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      1:       return d[7:0] * 32'h0101_0101;
      2:       return d[15:0] * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * off);
    case (f3)
      F3_B:  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      F3_BU: v = v % 256;
      F3_H:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      F3_HU: v = v % 65536;
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic drive_op(input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    valid_i      = 1'b1;
    mem_read_i   = ~wr;
    mem_write_i  = wr;
    funct3_i     = f3;
    addr_i       = a;
    store_data_i = d;
  endtask

  task automatic idle_inputs();
    valid_i     = 1'b0;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    flush_i     = 1'b0;
    hold_i      = 1'b0;
  endtask

  // One complete access with grant after d1 REQ cycles and response after d2 WAIT cycles.
  task automatic run_op(input string tag, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int d1, input int d2);
    int stalls = 0;
    @(negedge clk_i);
    drive_op(wr, f3, a, d);
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
    #1;
    if (!legal(wr, f3, a[1:0])) begin
      check({tag, " misalign"}, misalign_o, 1'b1);
      check({tag, " bad stall"}, stall_o, 1'b0);
      @(negedge clk_i); #1;
      check({tag, " bad req"}, dmem.req, 1'b0);
      check({tag, " bad ld"}, load_data_o, exp_ld);
      idle_inputs();
      return;
    end
    check({tag, " misalign"}, misalign_o, 1'b0);
    stalls += int'(stall_o);
    for (int k = 0; k <= d1; k++) begin
      @(negedge clk_i);
      dmem.gnt = (k == d1);
      #1;
      check({tag, " req"}, dmem.req, 1'b1);
      if (k == d1) begin
        check({tag, " addr"}, dmem.addr, a & 32'hFFFF_FFFC);
        check({tag, " be"}, dmem.be, ref_be(wr, f3, a[1:0]));
        check({tag, " we"}, dmem.we, wr);
        if (wr) check({tag, " wdata"}, dmem.wdata, ref_wdata(f3, d));
      end
      stalls += int'(stall_o);
    end
    if (!wr) begin
      for (int k = 0; k <= d2; k++) begin
        @(negedge clk_i);
        dmem.gnt    = 1'b0;
        dmem.rvalid = (k == d2);
        dmem.rdata  = (k == d2) ? rd : $urandom;
        #1;
        stalls += int'(stall_o);
      end
      exp_ld = ref_load(f3, a[1:0], rd);
    end
    @(negedge clk_i);
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
    #1;
    check({tag, " done stall"}, stall_o, 1'b0);
    check({tag, " stall cycles"}, stalls, wr ? 2 + d1 : 3 + d1 + d2);
    check({tag, " load_data"}, load_data_o, exp_ld);
    check({tag, " bus_err"}, bus_err_o, 1'b0);
    idle_inputs();
  endtask

  initial begin
    int cnt;
    logic seen;

    idle_inputs();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 32'h0;
    funct3_i = F3_W; addr_i = 32'h0; store_data_i = 32'h0;

    // Reset: a misaligned access presented during reset must not flag or stall.
    rst_i = 1'b1;
    drive_op(1'b0, F3_W, 32'h102, 32'h0);
    repeat (2) @(negedge clk_i);
    #1;
    check("rst misalign", misalign_o, 1'b0);
    check("rst stall", stall_o, 1'b0);
    check("rst req", dmem.req, 1'b0);
    check("rst be", dmem.be, 4'h0);
    check("rst ld", load_data_o, 32'h0);
    check("rst bus_err", bus_err_o, 1'b0);
    idle_inputs();
    rst_i = 1'b0;

    // Directed examples
    run_op("lw",  1'b0, F3_W,  32'h100, 32'h0,  32'hDEAD_BEEF, 0, 0);
    run_op("lb",  1'b0, F3_B,  32'h103, 32'h0,  32'h80FF_0000, 0, 0);
    run_op("lbu", 1'b0, F3_BU, 32'h103, 32'h0,  32'h80FF_0000, 1, 1);
    run_op("lhu", 1'b0, F3_HU, 32'h102, 32'h0,  32'h80FF_0000, 0, 2);
    run_op("sb",  1'b1, F3_B,  32'h201, 32'hAB, 32'h0, 0, 0);
    run_op("sh",  1'b1, F3_H,  32'h202, 32'h1234_5678, 32'h0, 2, 0);
    run_op("lw_mis", 1'b0, F3_W, 32'h102, 32'h0, 32'h0, 0, 0);

    // Flush while the grant is withheld
    @(negedge clk_i);
    drive_op(1'b0, F3_W, 32'h400, 32'h0);
    repeat (4) begin
      @(negedge clk_i); #1;
      check("flreq req", dmem.req, 1'b1);
    end
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    idle_inputs();
    #1;
    check("flreq dropped", dmem.req, 1'b0);
    check("flreq stall", stall_o, 1'b0);
    seen = 1'b0;
    repeat (T + 2) begin
      @(negedge clk_i); #1;
      seen = seen | bus_err_o | dmem.req;
    end
    check("flreq quiet", seen, 1'b0);

    // Flush while waiting for read data: the response is drained, result kept
    @(negedge clk_i);
    drive_op(1'b0, F3_W, 32'h500, 32'h0);
    @(negedge clk_i); dmem.gnt = 1'b1;
    @(negedge clk_i); dmem.gnt = 1'b0; flush_i = 1'b1;
    @(negedge clk_i); idle_inputs(); dmem.rvalid = 1'b1; dmem.rdata = 32'h1357_9BDF;
    @(negedge clk_i); dmem.rvalid = 1'b0; #1;
    check("flwait ld", load_data_o, exp_ld);
    check("flwait stall", stall_o, 1'b0);
    check("flwait req", dmem.req, 1'b0);
    // A stray response in IDLE is ignored
    @(negedge clk_i); dmem.rvalid = 1'b1; dmem.rdata = 32'h2468_ACE0;
    @(negedge clk_i); dmem.rvalid = 1'b0; #1;
    check("late rvalid", load_data_o, exp_ld);

    // Timeout with no grant, then hold in DONE
    @(negedge clk_i);
    drive_op(1'b0, F3_W, 32'h600, 32'h0);
    cnt = 0;
    for (int n = 0; n < 3 * T; n++) begin
      @(negedge clk_i); #1;
      if (dmem.req) cnt++;
      else break;
    end
    check("to req cycles", cnt, T);
    check("to bus_err", bus_err_o, 1'b1);
    check("to ld zero", load_data_o, 32'h0);
    check("to stall", stall_o, 1'b0);
    exp_ld = 32'h0;
    hold_i = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_i); #1;
      if (n == 0) check("to pulse", bus_err_o, 1'b0);
      seen = seen | dmem.req | stall_o;
    end
    check("hold no reissue", seen, 1'b0);
    idle_inputs();

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      bit wr;
      logic [2:0] f3;
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      run_op($sformatf("rnd%0d", i), wr, f3, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) @(negedge clk_i);
    end

    // Reset in the middle of a read
    @(negedge clk_i);
    drive_op(1'b0, F3_W, 32'h300, 32'h0);
    @(negedge clk_i); dmem.gnt = 1'b1;
    @(negedge clk_i); dmem.gnt = 1'b0; rst_i = 1'b1; #1;
    check("rstw stall forced", stall_o, 1'b0);
    @(negedge clk_i); #1;
    check("rstw req", dmem.req, 1'b0);
    check("rstw addr", dmem.addr, 32'h0);
    check("rstw be", dmem.be, 4'h0);
    check("rstw wdata", dmem.wdata, 32'h0);
    check("rstw we", dmem.we, 1'b0);
    check("rstw ld", load_data_o, 32'h0);
    check("rstw bus_err", bus_err_o, 1'b0);
    rst_i = 1'b0;
    idle_inputs();
    exp_ld = 32'h0;
    run_op("post rst", 1'b0, F3_H, 32'h7FE, 32'h0, 32'h8001_0000, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
